// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter: FSM state encoding,
// default per-byte timeout and the round-robin pointer advance helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int DEFAULT_TIMEOUT = 16384;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any
);

    int w_idx;

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (req[w_idx]) begin
                any               = 1'b1;
                gnt_idx           = IDW'(w_idx);
                gnt_onehot        = '0;
                gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock feeding one uart_tx transmitter.
// Optional per-byte abort timer enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_ctrl,
    output logic [7:0]           tx_byte,
    input  logic                 tx_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic                 tx_timeout,
`endif
    output state_t               dbg_state
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IDW < $clog2(NUM_REQ) || TIMEOUT < 2) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    // Handshake: a byte moves on a cycle where req_valid[i] && req_ready[i];
    // req_ready is a one-hot pulse, and tx_ctrl follows exactly one cycle later.
    state_t               r_state, w_state_nx;
    logic [IDW-1:0]       r_ptr, r_grant;
    logic [7:0]           r_byte;
    logic                 r_last, r_busy;

    logic [NUM_REQ-1:0]   w_pick_onehot, w_cand_onehot;
    logic [IDW-1:0]       w_pick_idx, w_cand_idx;
    logic                 w_pick_any, w_cand_ok;
    logic                 w_take, w_release, w_tmo, w_tmo_hit;
    logic [7:0]           w_cand_byte;
    logic                 w_cand_last;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req        (req_valid),
        .ptr        (r_ptr),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    // While a packet is open only the owner may be granted.
    assign w_cand_idx    = r_busy ? r_grant : w_pick_idx;
    assign w_cand_ok     = r_busy ? req_valid[r_grant] : w_pick_any;
    assign w_cand_onehot = r_busy ? (NUM_REQ'(1) << r_grant) : w_pick_onehot;
    assign w_cand_byte   = req_data[{w_cand_idx, 3'b000} +: 8];
    assign w_cand_last   = req_last[w_cand_idx];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_cnt <= '0;
        end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tmo_hit  = (r_state == WAIT_BUSY || r_state == WAIT_DONE) && (r_cnt == CW'(TIMEOUT - 1));
    assign tx_timeout = w_tmo;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_release  = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && tx_ready && w_cand_ok) begin
                    w_take     = 1'b1;
                    w_state_nx = LAUNCH;
                end
            end
            LAUNCH: w_state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (w_tmo_hit) begin
                    w_tmo      = 1'b1;
                    w_state_nx = IDLE;
                end else if (!tx_ready) begin
                    w_state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w_tmo_hit) begin
                    w_tmo      = 1'b1;
                    w_state_nx = IDLE;
                end else if (tx_ready) begin
                    if (r_last) begin
                        w_release  = 1'b1;
                        w_state_nx = IDLE;
                    end else if (req_valid[r_grant]) begin
                        w_take     = 1'b1;
                        w_state_nx = LAUNCH;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_byte  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_take) begin
                r_grant <= w_cand_idx;
                r_byte  <= w_cand_byte;
                r_last  <= w_cand_last;
                r_busy  <= 1'b1;
            end
            if (w_release || w_tmo) begin
                r_busy <= 1'b0;
                r_ptr  <= IDW'(next_idx(int'(r_grant), NUM_REQ));
            end
        end
    end

    assign req_ready = w_take ? w_cand_onehot : '0;
    assign tx_ctrl   = (r_state == LAUNCH);
    assign tx_byte   = r_byte;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a stub transmitter; the timer
// scenario is included when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int IDW      = 2;
    localparam int BUSY_CYC = 6;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = DEFAULT_TIMEOUT;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_ctrl;
    logic [7:0]           tx_byte;
    logic                 tx_ready;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    state_t               dbg_state;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic                 tx_timeout;
`endif

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_ctrl    (tx_ctrl),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .tx_timeout (tx_timeout),
`endif
        .dbg_state  (dbg_state)
    );

    // stub transmitter: busy for BUSY_CYC cycles after each start pulse
    logic stub_stuck    = 1'b0;
    logic stub_hold_low = 1'b0;
    int   stub_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) stub_cnt <= 0;
        else if (tx_ctrl && !stub_stuck) stub_cnt <= BUSY_CYC;
        else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end
    assign tx_ready = (stub_cnt == 0) && !stub_hold_low;

    // scoreboard
    logic [8:0] src_q[NUM_REQ][$];
    logic [9:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0, acc_cyc = 0, launch_cyc = 0, tmo_cyc = 0;
    logic [NUM_REQ-1:0] acc_seen = '0;
    bit tmo_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) begin
                req_valid[i]      = 1'b1;
                req_last[i]       = src_q[i][0][8];
                req_data[8*i +: 8] = src_q[i][0][7:0];
            end else begin
                req_valid[i]      = 1'b0;
                req_last[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push(input int who, input logic [7:0] d, input logic last);
        src_q[who].push_back({last, d});
        drive();
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] w;
        logic [9:0] e;
        @(negedge clk);
        cyc++;
        w = req_valid & req_ready;
        if (w != '0) begin
            chk("ready_onehot", 32'($onehot(w)), 1);
            acc_cyc  = cyc;
            acc_seen = acc_seen | w;
            for (int i = 0; i < NUM_REQ; i++)
                if (w[i]) void'(src_q[i].pop_front());
        end
        if (tx_ctrl) begin
            launch_cyc = cyc;
            chk("tx_ctrl_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant_id", grant_id, e[9:8]);
                chk("tx_byte", tx_byte, e[7:0]);
                chk("accept_to_ctrl", cyc - acc_cyc, 1);
                chk("busy_at_launch", busy, 1);
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (tx_timeout && !tmo_seen) begin
            tmo_seen = 1'b1;
            tmo_cyc  = cyc;
        end
`endif
        @(posedge clk);
        #1;
        drive();
    endtask

    // wait until all expected bytes went out and the FSM sits in IDLE with the given busy
    task automatic settle(input string tag, input logic want_busy, input int max_cyc);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && dbg_state == IDLE && busy == want_busy) && n < max_cyc) begin
            step();
            n++;
        end
        chk({tag, "_settle_in_budget"}, 32'(n < max_cyc), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // reset values
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_ctrl", tx_ctrl, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;

        // single-byte packet on an idle link
        exp_q.push_back({2'd1, 8'hA5});
        push(1, 8'hA5, 1'b1);
        settle("single", 1'b0, 60);
        chk("single_grant_held", grant_id, 1);

        // tx_ready low in IDLE blocks grants; ptr=2 so requester 2 is next
        stub_hold_low = 1'b1;
        push(2, 8'h5A, 1'b1);
        repeat (5) step();
        chk("no_grant_tx_busy", src_q[2].size(), 1);
        chk("no_busy_tx_busy", busy, 0);
        stub_hold_low = 1'b0;
        exp_q.push_back({2'd2, 8'h5A});
        settle("after_hold", 1'b0, 60);

        // asynchronous reset while waiting for the byte to finish
        exp_q.push_back({2'd1, 8'h77});
        push(1, 8'h77, 1'b0);
        begin
            int n;
            n = 0;
            while (dbg_state != WAIT_DONE && n < 40) begin
                step();
                n++;
            end
            chk("reach_wait_done", dbg_state, WAIT_DONE);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_tx_ctrl", tx_ctrl, 0);
        chk("arst_tx_byte", tx_byte, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_busy", busy, 0);
        chk("arst_state", dbg_state, IDLE);
        @(posedge clk); #1 rst = 1'b0;
        acc_seen = '0;
        repeat (10) step();
        chk("arst_no_accept_after", acc_seen, 0);

        // two requesters with single-byte packets alternate from ptr=0
        push(0, 8'h10, 1'b1);
        push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b1);
        push(2, 8'h21, 1'b1);
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd2, 8'h20});
        exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd2, 8'h21});
        settle("alternate", 1'b0, 200);

        // ptr=3: requester 0 locks for a 3-byte packet while requester 3 waits
        exp_q.push_back({2'd0, 8'h01});
        exp_q.push_back({2'd0, 8'h02});
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        step();
        push(3, 8'h33, 1'b1);
        settle("lock_pre_gap", 1'b1, 100);
        acc_seen = '0;
        repeat (50) step();
        chk("lock_gap_no_accept", acc_seen, 0);
        chk("lock_gap_busy", busy, 1);
        chk("lock_gap_owner", grant_id, 0);
        exp_q.push_back({2'd0, 8'h03});
        exp_q.push_back({2'd3, 8'h33});
        push(0, 8'h03, 1'b1);
        settle("lock_done", 1'b0, 100);
        chk("lock_last_owner", grant_id, 3);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // transmitter never starts: timer aborts the packet and frees the link
        do_reset();
        stub_stuck = 1'b1;
        exp_q.push_back({2'd1, 8'hA1});
        push(1, 8'hA1, 1'b0);
        push(2, 8'hB2, 1'b1);
        begin
            int n;
            n = 0;
            while (!tmo_seen && n < 200) begin
                step();
                n++;
            end
            chk("tmo_seen", 32'(tmo_seen), 1);
        end
        chk("tmo_delay", tmo_cyc - launch_cyc, TMO);
        chk("tmo_busy_cleared", busy, 0);
        stub_stuck = 1'b0;
        exp_q.push_back({2'd2, 8'hB2});
        settle("tmo_next", 1'b0, 100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
